eth_frame_serializer: RTL and testbench

Downstream stage of the Ethernet frame assembler. Accepts one fully assembled 568-bit frame (preamble, SFD, SA, DA, type, payload, CRC; MSB first) per valid/ready handshake. Streams the frame out one byte per transfer on a byte-wide valid/ready interface, preamble byte first. Enforces an inter-frame gap before accepting the next frame.

---
 rtl/eth_pkg.sv | 11 +
 rtl/eth_ifg_timer.sv | 23 ++
 rtl/eth_frame_serializer.sv | 87 ++++++++
 tb/tb_eth_frame_serializer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared frame geometry, framing byte constants and FSM state type
// for the Ethernet frame serializer.
package eth_pkg;
  localparam int FRAME_W     = 568;
  localparam int FRAME_BYTES = FRAME_W / 8;

  localparam logic [7:0] SFD_BYTE      = 8'hAB;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
endpackage

// File: rtl/eth_ifg_timer.sv
// Inter-frame gap timer: start loads IFG_CYCLES-1 and counts down;
// done is high while the count sits at zero.
module eth_ifg_timer import eth_pkg::*; #(
  parameter int IFG_CYCLES = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);
  localparam int W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (start)       cnt <= LOAD;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/eth_frame_serializer.sv
// Serializes one assembled Ethernet frame into a byte stream (MSB first)
// with an inter-frame gap. Optional SFD check: define SFD_CHECK_EN.
module eth_frame_serializer import eth_pkg::*; #(
  parameter int IFG_CYCLES = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_sof,
  output logic               tx_eof,
  output logic               busy,
  output logic               sfd_err
);
  localparam int CNT_W = $clog2(FRAME_BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BYTES - 1);

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic               accept, sfd_ok, tx_hs, last_hs, gap_done;

  assign accept  = frame_valid && frame_ready;
  assign tx_hs   = tx_valid && tx_ready;
  assign last_hs = tx_hs && (cnt == LAST);

`ifdef SFD_CHECK_EN
  assign sfd_ok = (frame_in[FRAME_W-57 -: 8] == SFD_BYTE);

  // Rejected frames still complete the handshake; flag them one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sfd_err <= 1'b0;
    else     sfd_err <= accept && !sfd_ok;
  end
`else
  assign sfd_ok  = 1'b1;
  assign sfd_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && sfd_ok) state_nxt = SEND;
      SEND: if (last_hs)          state_nxt = (IFG_CYCLES > 0) ? GAP : IDLE;
      GAP:  if (gap_done)         state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_ready = (state == IDLE) && !rst;
    tx_valid    = (state == SEND);
    tx_data     = tx_valid ? shreg[FRAME_W-1 -: 8] : 8'h00;
    tx_sof      = tx_valid && (cnt == '0);
    tx_eof      = tx_valid && (cnt == LAST);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept && sfd_ok) begin
      shreg <= frame_in;
      cnt   <= '0;
    end else if (tx_hs) begin
      shreg <= {shreg[FRAME_W-9:0], 8'h00};
      cnt   <= cnt + 1'b1;
    end
  end

  eth_ifg_timer #(.IFG_CYCLES(IFG_CYCLES)) u_ifg (
    .clk   (clk),
    .rst   (rst),
    .start (last_hs),
    .done  (gap_done)
  );
endmodule

// File: tb/tb_eth_frame_serializer.sv
// Self-checking bench for eth_frame_serializer: byte scoreboard, stall
// stability, gap timing, back-to-back, mid-frame reset, IFG=0 instance.
module tb_eth_frame_serializer;
  import eth_pkg::*;

  localparam int IFG = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic [FRAME_W-1:0] frame_in;
  logic               frame_valid, frame_ready;
  logic [7:0]         tx_data;
  logic               tx_valid, tx_ready, tx_sof, tx_eof, busy, sfd_err;

  logic [FRAME_W-1:0] fi0;
  logic               fv0, fr0, tv0, ts0, te0, b0, se0;
  logic [7:0]         td0;

  always #5 clk = ~clk;

  eth_frame_serializer #(.IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy),
    .sfd_err(sfd_err)
  );

  eth_frame_serializer #(.IFG_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .frame_in(fi0), .frame_valid(fv0),
    .frame_ready(fr0), .tx_data(td0), .tx_valid(tv0),
    .tx_ready(1'b1), .tx_sof(ts0), .tx_eof(te0), .busy(b0),
    .sfd_err(se0)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout or unexpected event", name);
  endtask

  function automatic logic [FRAME_W-1:0] mk_frame(input logic [7:0] sfd, input logic [7:0] pstart);
    logic [7:0] b [FRAME_BYTES];
    logic [7:0] crc [5];
    logic [FRAME_W-1:0] f;
    crc = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    for (int i = 0; i < 7; i++) b[i] = 8'h55;
    b[7] = sfd;
    for (int i = 0; i < 5; i++) begin
      b[8+i]  = 8'(8'h01 + i);
      b[13+i] = 8'(8'h0A + i);
    end
    b[18] = 8'h08;
    b[19] = 8'h00;
    for (int i = 0; i < 46; i++) b[20+i] = pstart + 8'(i);
    for (int i = 0; i < 5; i++)  b[66+i] = crc[i];
    f = '0;
    for (int i = 0; i < FRAME_BYTES; i++) f[FRAME_W-1-8*i -: 8] = b[i];
    return f;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed { logic [7:0] data; logic sof; logic eof; } exp_t;
  exp_t sb[$];

  logic [7:0] cap_d [FRAME_BYTES];
  logic       cap_s [FRAME_BYTES];
  logic       cap_e [FRAME_BYTES];
  int  ncap = 0, fb = 0, nframes = 0;
  int  eof_cyc = 0, last_acc = 0;
  bit  in_gap = 0, prev_stall = 0, exp_err = 0, b2b = 0, prev_b2b = 0;
  logic [7:0] pd; logic ps, pe;

  always @(negedge clk) begin
    if (rst) begin
      in_gap = 0; prev_stall = 0; exp_err = 0; fb = 0;
    end else begin
      chk("sfd_err", sfd_err, exp_err);
      if (exp_err) begin
        chk("rej_busy", busy, 0);
        chk("rej_txv", tx_valid, 0);
      end
      exp_err = 0;
      if (prev_stall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, pd);
        chk("stall_sof", tx_sof, ps);
        chk("stall_eof", tx_eof, pe);
      end
      if (in_gap) begin
        if (frame_ready) begin
          // ready is visible IFG clock edges after the eof handshake edge
          chk("gap_len", cyc - eof_cyc, IFG + 1);
          in_gap = 0;
        end else chk("gap_txv", tx_valid, 0);
      end
      if (frame_ready && busy) fail_now("ready_while_busy");
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) fail_now("sb_underflow");
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("tx_data", tx_data, e.data);
          chk("tx_sof", tx_sof, e.sof);
          chk("tx_eof", tx_eof, e.eof);
        end
        if (ncap < FRAME_BYTES) begin
          cap_d[ncap] = tx_data; cap_s[ncap] = tx_sof; cap_e[ncap] = tx_eof;
          ncap++;
        end
        fb = tx_sof ? 1 : fb + 1;
        if (tx_eof) begin
          eof_cyc = cyc; in_gap = 1; nframes++;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      pd = tx_data; ps = tx_sof; pe = tx_eof;
      if (frame_valid && frame_ready) begin
        if (b2b && prev_b2b) chk("b2b_period", cyc - last_acc, IFG + FRAME_BYTES + 1);
        last_acc = cyc; prev_b2b = b2b;
`ifdef SFD_CHECK_EN
        if (frame_in[FRAME_W-57 -: 8] != 8'hAB) exp_err = 1;
        else
`endif
        for (int i = 0; i < FRAME_BYTES; i++)
          sb.push_back('{frame_in[FRAME_W-1-8*i -: 8], i == 0, i == FRAME_BYTES-1});
      end
    end
  end

  // IFG_CYCLES=0 instance: length, first byte, back-to-back period
  int c0 = 0, acc0 = 0, lacc0 = 0;
  bit post_eof0 = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (post_eof0) chk("ifg0_ready_after_eof", fr0, 1);
      post_eof0 = 0;
      if (tv0) begin
        if (ts0) chk("ifg0_first_byte", td0, 8'h55);
        c0++;
        if (te0) begin
          chk("ifg0_len", c0, FRAME_BYTES);
          c0 = 0; post_eof0 = 1;
        end
      end
      if (fv0 && fr0) begin
        if (acc0 > 0) chk("ifg0_period", cyc - lacc0, FRAME_BYTES + 1);
        lacc0 = cyc; acc0++;
      end
    end
  end

  // ---------------- driver ----------------
  bit stall = 0;

  task automatic tick();
    @(posedge clk); #1;
    if (stall) tx_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!frame_ready && n < 500) begin tick(); n++; end
    if (!frame_ready) fail_now(name);
  endtask

  task automatic send(input logic [FRAME_W-1:0] f, input string name);
    frame_in = f; frame_valid = 1;
    wait_ready(name);
    tick();
    frame_valid = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 5000) begin tick(); n++; end
    if (busy || sb.size() != 0) fail_now(name);
  endtask

  typedef struct { int idx; logic [7:0] data; logic sof; logic eof; } vec_t;
  vec_t tbl [15];

  initial begin
    int n, fr_before, exp_frames;
    tbl = '{'{0, 8'h55, 1, 0}, '{6, 8'h55, 0, 0}, '{7, 8'hAB, 0, 0},
            '{8, 8'h01, 0, 0}, '{12, 8'h05, 0, 0}, '{13, 8'h0A, 0, 0},
            '{17, 8'h0E, 0, 0}, '{18, 8'h08, 0, 0}, '{19, 8'h00, 0, 0},
            '{20, 8'h00, 0, 0}, '{21, 8'h01, 0, 0}, '{65, 8'h2D, 0, 0},
            '{66, 8'hDE, 0, 0}, '{69, 8'hEF, 0, 0}, '{70, 8'h01, 0, 1}};
    rst = 1; frame_valid = 0; frame_in = '0; tx_ready = 1; fv0 = 0; fi0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_sof", tx_sof, 0);
    chk("rst_tx_eof", tx_eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sfd_err", sfd_err, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", frame_ready, 1);

    // 1: nominal frame, tx_ready high
    send(mk_frame(8'hAB, 8'h00), "t1_accept");
    wait_done("t1_done");
    for (int i = 0; i < 15; i++) begin
      chk("vec_data", cap_d[tbl[i].idx], tbl[i].data);
      chk("vec_sof", cap_s[tbl[i].idx], tbl[i].sof);
      chk("vec_eof", cap_e[tbl[i].idx], tbl[i].eof);
    end

    // 2: random back-pressure
    stall = 1;
    send(mk_frame(8'hAB, 8'h40), "t2_accept");
    wait_done("t2_done");
    stall = 0; tx_ready = 1;

    // 3: back-to-back with frame_valid held
    b2b = 1;
    frame_in = mk_frame(8'hAB, 8'h80); frame_valid = 1;
    wait_ready("t3_a"); tick();
    frame_in = mk_frame(8'hAB, 8'hC0);
    wait_ready("t3_b"); tick();
    frame_valid = 0;
    wait_done("t3_done");
    b2b = 0;

    // 4: asynchronous reset at byte 30
    send(mk_frame(8'hAB, 8'h10), "t4_accept");
    n = 0;
    while (!(tx_valid && fb == 30) && n < 200) begin tick(); n++; end
    if (!(tx_valid && fb == 30)) fail_now("t4_byte30");
    #2 rst = 1;
    #1;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", frame_ready, 0);
    sb.delete();
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("midrst_release_ready", frame_ready, 1);
    fr_before = nframes;
    send(mk_frame(8'hAB, 8'h20), "t4b_accept");
    wait_done("t4b_done");
    chk("midrst_full_frame", nframes - fr_before, 1);

    // 5: bad SFD followed by a good frame
    fr_before = nframes;
    send(mk_frame(8'hAA, 8'h30), "t5_accept");
`ifdef SFD_CHECK_EN
    tick(); tick();
    chk("bad_sfd_no_frame", nframes - fr_before, 0);
`else
    wait_done("t5_done");
    chk("bad_sfd_sent", nframes - fr_before, 1);
`endif
    send(mk_frame(8'hAB, 8'h50), "t5b_accept");
    wait_done("t5b_done");

    // 6: IFG_CYCLES=0 instance, back-to-back
    fi0 = mk_frame(8'hAB, 8'h00); fv0 = 1;
    n = 0;
    while (acc0 < 2 && n < 500) begin tick(); n++; end
    if (acc0 < 2) fail_now("ifg0_accepts");
    fv0 = 0;
    n = 0;
    while (b0 && n < 500) begin tick(); n++; end
    if (b0) fail_now("ifg0_done");
    tick();

`ifdef SFD_CHECK_EN
    exp_frames = 6;
`else
    exp_frames = 7;
`endif
    chk("frame_count", nframes, exp_frames);
    chk("sb_empty", sb.size(), 0);
    chk("ifg0_accept_count", acc0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
